// File: rtl/rb_dump_controller.sv
// ---------------------------------------------------------------------------
// rb_dump_controller
//
// Debug-side sequencer that walks the whole register bank, reads each
// register through the bank's debug read port and streams it out to the
// debug UART transmitter, least-significant byte first.
//
// Ports
//   i_clock            : single clock, rising-edge
//   i_reset            : synchronous, active-low reset
//   i_start            : dump request pulse (only looked at while idle)
//   i_rb_data          : bank read data, valid one cycle after read enable
//   o_rb_read_enable   : bank debug read enable (one cycle per register)
//   o_rb_read_address  : bank debug read address
//   o_halt             : stalls the pipeline's use of the bank while busy
//   o_tx_data          : byte presented to the transmitter
//   o_tx_valid         : o_tx_data is valid
//   i_tx_ready         : transmitter takes the byte on valid && ready
//   o_busy             : high in every state except idle
//   o_done             : one-cycle pulse after the final byte is taken
// ---------------------------------------------------------------------------
module rb_dump_controller #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 5,
    parameter int BANK_DEPTH = 32,
    parameter int NB_BYTE    = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_rb_data,
    output logic               o_rb_read_enable,
    output logic [NB_ADDR-1:0] o_rb_read_address,
    output logic               o_halt,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int NB_WORD_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_BCNT       = (NB_WORD_BYTES > 1) ? $clog2(NB_WORD_BYTES) : 1;

    localparam logic [NB_ADDR-1:0] LAST_IDX  = NB_ADDR'(BANK_DEPTH - 1);
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_WORD_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t             state_q,    state_d;
    logic [NB_ADDR-1:0] index_q,    index_d;
    logic [NB_BCNT-1:0] byte_cnt_q, byte_cnt_d;
    logic [NB_DATA-1:0] shift_q,    shift_d;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    index_d = '0;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                state_d = ST_WAIT;
            end

            // Bank data is registered: the read issued in REQ is visible on
            // i_rb_data during this cycle and captured at its closing edge.
            ST_WAIT: begin
                shift_d    = i_rb_data;
                byte_cnt_d = '0;
                state_d    = ST_SEND;
            end

            ST_SEND: begin
                if (i_tx_ready) begin
                    shift_d    = shift_q >> NB_BYTE;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        if (index_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            index_d = index_q + 1'b1;
                            state_d = ST_REQ;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: pure decode of registered state, so o_tx_valid never depends
    // on i_tx_ready within a cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        o_busy            = (state_q != ST_IDLE);
        o_halt            = (state_q != ST_IDLE);
        o_rb_read_enable  = (state_q == ST_REQ);
        o_rb_read_address = index_q;
        o_tx_valid        = (state_q == ST_SEND);
        o_tx_data         = (state_q == ST_SEND) ? shift_q[NB_BYTE-1:0] : '0;
        o_done            = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_rb_dump_controller.sv
// ---------------------------------------------------------------------------
// tb_rb_dump_controller
//
// Randomised bench for rb_dump_controller. A behavioural model tracks the
// dump as a position on a timeline (register, slot within register) and
// derives every output from the bank contents each cycle; a scoreboard
// collects accepted bytes and compares them against the bank image.
// ---------------------------------------------------------------------------
module tb_rb_dump_controller;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 5;
    localparam int D       = 32;
    localparam int NB_BYTE = 8;
    localparam int NBY     = NB_DATA / NB_BYTE;
    localparam int STEPS   = 2 + NBY;          // REQ, WAIT, then one slot per byte
    localparam int DONE_ST = D * STEPS;

    logic               i_clock    = 1'b0;
    logic               i_reset    = 1'b0;
    logic               i_start    = 1'b0;
    logic [NB_DATA-1:0] i_rb_data  = '0;
    logic               i_tx_ready = 1'b1;
    logic               o_rb_read_enable;
    logic [NB_ADDR-1:0] o_rb_read_address;
    logic               o_halt;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_valid;
    logic               o_busy;
    logic               o_done;

    rb_dump_controller #(
        .NB_DATA    (NB_DATA),
        .NB_ADDR    (NB_ADDR),
        .BANK_DEPTH (D),
        .NB_BYTE    (NB_BYTE)
    ) dut (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .i_start           (i_start),
        .i_rb_data         (i_rb_data),
        .o_rb_read_enable  (o_rb_read_enable),
        .o_rb_read_address (o_rb_read_address),
        .o_halt            (o_halt),
        .o_tx_data         (o_tx_data),
        .o_tx_valid        (o_tx_valid),
        .i_tx_ready        (i_tx_ready),
        .o_busy            (o_busy),
        .o_done            (o_done)
    );

    always #5 i_clock = ~i_clock;

    // Register bank with a registered read port
    logic [NB_DATA-1:0] bank [D];
    always @(posedge i_clock)
        if (o_rb_read_enable) i_rb_data <= bank[o_rb_read_address];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: step = -1 idle, 0..DONE_ST-1 position in the dump
    // timeline, DONE_ST the completion cycle.
    // -----------------------------------------------------------------------
    int         step      = -1;
    int         cyc       = 0;
    int         begin_cyc = 0;
    logic [7:0] got [$];

    always @(posedge i_clock) begin
        cyc++;
        if (o_tx_valid && i_tx_ready && i_reset) got.push_back(o_tx_data);
        if (!i_reset)                                step = -1;
        else if (step == -1) begin
            if (i_start) begin step = 0; begin_cyc = cyc; end
        end
        else if (step == DONE_ST)                    step = -1;
        else if ((step % STEPS) < 2 || i_tx_ready)   step++;
    end

    // -----------------------------------------------------------------------
    // Per-cycle compare against the model (sampled on the falling edge)
    // -----------------------------------------------------------------------
    bit         chk_en     = 0;
    int         n_busy     = 0;
    int         n_re       = 0;
    int         n_done     = 0;
    int         done_rel   = 0;
    bit         done_seen  = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data  = '0;

    always @(negedge i_clock) begin
        if (chk_en) begin
            int r, ph;
            logic e_busy, e_re, e_valid, e_done;
            r  = (step >= 0) ? step / STEPS : 0;
            ph = (step >= 0) ? step % STEPS : 0;
            e_busy  = (step >= 0);
            e_done  = (step == DONE_ST);
            e_re    = (step >= 0) && !e_done && (ph == 0);
            e_valid = (step >= 0) && !e_done && (ph >= 2);
            chk("busy",  32'(o_busy),           32'(e_busy));
            chk("halt",  32'(o_halt),           32'(e_busy));
            chk("rd_en", 32'(o_rb_read_enable), 32'(e_re));
            chk("valid", 32'(o_tx_valid),       32'(e_valid));
            chk("done",  32'(o_done),           32'(e_done));
            if (e_busy && !e_done && ph < 2)
                chk("rd_addr", 32'(o_rb_read_address), 32'(r));
            if (e_valid)
                chk("tx_data", 32'(o_tx_data), (bank[r] >> (NB_BYTE * (ph - 2))) & 32'hFF);
            if (prev_stall) begin
                chk("stall_valid", 32'(o_tx_valid), 32'd1);
                chk("stall_data",  32'(o_tx_data),  32'(prev_data));
            end
            prev_stall = o_tx_valid && !i_tx_ready && i_reset;
            prev_data  = o_tx_data;
            if (o_busy)           n_busy++;
            if (o_rb_read_enable) n_re++;
            if (o_done) begin
                n_done++;
                done_rel  = cyc - begin_cyc + 1;
                done_seen = 1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Ready driver: tied high, random, plus one forced 5-cycle stall when
    // byte 2 of r3 is first presented.
    // -----------------------------------------------------------------------
    bit rnd_ready = 0;
    bit stall_arm = 0;
    bit stalled   = 0;
    int stall_cnt = 0;

    always @(posedge i_clock) begin
        #1;
        if (stall_arm && !stalled && step == 3 * STEPS + 2 + 2) begin
            stalled   = 1;
            stall_cnt = 5;
        end
        if (stall_cnt > 0) begin
            i_tx_ready = 1'b0;
            stall_cnt--;
        end else begin
            i_tx_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge i_clock); #1; end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
    endtask

    task automatic clear_stats();
        n_busy = 0; n_re = 0; n_done = 0; done_rel = 0; done_seen = 0;
        got.delete();
    endtask

    task automatic wait_done(input int max, input string nm);
        int i = 0;
        while (!done_seen && i < max) begin tick(1); i++; end
        if (!done_seen) begin
            n_checks++; n_err++;
            $display("FAIL %s: no done within %0d cycles", nm, max);
        end
        tick(2);
    endtask

    task automatic wait_step(input int target, input int max, input string nm);
        int i = 0;
        while (step != target && i < max) begin tick(1); i++; end
        if (step != target) begin
            n_checks++; n_err++;
            $display("FAIL %s: step %0d not reached (at %0d)", nm, target, step);
        end
    endtask

    task automatic check_stream(input string nm);
        chk({nm, "_bytes"}, got.size(), D * NBY);
        for (int i = 0; i < got.size() && i < D * NBY; i++) begin
            logic [NB_DATA-1:0] w;
            w = bank[i / NBY];
            chk({nm, "_byte"}, 32'(got[i]), 32'(w[(i % NBY) * NB_BYTE +: NB_BYTE]));
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_rd_en"},   32'(o_rb_read_enable),  32'd0);
        chk({nm, "_rd_addr"}, 32'(o_rb_read_address), 32'd0);
        chk({nm, "_halt"},    32'(o_halt),            32'd0);
        chk({nm, "_tx_data"}, 32'(o_tx_data),         32'd0);
        chk({nm, "_valid"},   32'(o_tx_valid),        32'd0);
        chk({nm, "_busy"},    32'(o_busy),            32'd0);
        chk({nm, "_done"},    32'(o_done),            32'd0);
    endtask

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    logic [7:0] lit [16];

    initial begin
        lit = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00,
                8'hC8, 8'h00, 8'h00, 8'h00, 8'hA4, 8'h01, 8'h00, 8'h00};
        for (int i = 0; i < D; i++) bank[i] = '0;
        bank[0] = 32'd255; bank[1] = 32'd10; bank[2] = 32'd200; bank[3] = 32'd420;

        // Reset
        tick(1);
        chk_en = 1;
        tick(2);
        check_all_zero("reset");
        i_reset = 1'b1;
        tick(2);

        // Basic dump, ready tied high
        clear_stats();
        pulse_start();
        wait_done(400, "basic");
        check_stream("basic");
        for (int i = 0; i < 16; i++) chk("basic_lit", 32'(got[i]), 32'(lit[i]));
        chk("basic_done_cycle", done_rel, 193);
        chk("basic_done_count", n_done,   1);
        chk("basic_rd_en_count", n_re,    32);
        chk("basic_busy_cycles", n_busy,  193);

        // Backpressure: forced stall on r3 byte 2 plus random ready
        clear_stats();
        stall_arm = 1; rnd_ready = 1;
        pulse_start();
        wait_done(2000, "backpressure");
        check_stream("bp");
        chk("bp_forced_stall", 32'(stalled), 32'd1);
        chk("bp_done_count",   n_done, 1);
        stall_arm = 0; rnd_ready = 0;
        tick(2);

        // Start while busy is ignored
        clear_stats();
        pulse_start();           // returns at start of cycle 1
        tick(9);
        pulse_start();           // sampled at end of cycle 10
        tick(89);
        pulse_start();           // sampled at end of cycle 100
        wait_done(400, "start_busy");
        check_stream("sb");
        chk("sb_done_cycle", done_rel, 193);
        chk("sb_done_count", n_done,   1);

        // Reset during SEND of r5
        clear_stats();
        pulse_start();
        wait_step(5 * STEPS + 3, 300, "rst_mid");
        i_reset = 1'b0;
        tick(1);
        check_all_zero("rst_mid");
        i_reset = 1'b1;
        tick(2);
        clear_stats();
        pulse_start();
        wait_done(400, "rst_restart");
        chk("rst_first_byte", (got.size() > 0) ? 32'(got[0]) : 32'hDEAD, 32'hFF);
        check_stream("rst");
        chk("rst_done_cycle", done_rel, 193);

        // Back-to-back with a random bank: start held through DONE is ignored,
        // then accepted in the following idle cycle.
        for (int i = 0; i < D; i++) bank[i] = $urandom;
        clear_stats();
        pulse_start();
        wait_step(DONE_ST, 400, "b2b_first");
        check_stream("b2b_a");
        i_start = 1'b1;
        tick(1);
        chk("b2b_idle_gap", 32'(o_busy), 32'd0);
        tick(1);
        i_start = 1'b0;
        chk("b2b_restart_busy", 32'(o_busy), 32'd1);
        chk("b2b_restart_req",  32'(o_rb_read_enable), 32'd1);
        clear_stats();
        wait_done(400, "b2b_second");
        check_stream("b2b_b");
        chk("b2b_done_count", n_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Hard stop so the run can never hang
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rb_dump_controller.md
# rb_dump_controller

Debug-side sequencer that dumps the whole register bank, one register at a time, out through the debug UART transmitter as a byte stream. It halts the pipeline's use of the bank while running and drives the bank's debug read port (read enable and read address). It captures each registered read result and serialises it least-significant byte first over a valid/ready byte interface. The debug unit starts it with a single pulse and is told when the dump completes.

## Interface
- NB_DATA, 32, register width; must be a multiple of NB_BYTE
- NB_ADDR, 5, register address width
- BANK_DEPTH, 32, registers dumped (addresses 0..BANK_DEPTH-1); BANK_DEPTH <= 2^NB_ADDR
- NB_BYTE, 8, transmit byte width
- i_clock  in  1  single clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_start  in  1  dump request; sampled only in IDLE
- i_rb_data  in  NB_DATA  bank read-port A data (registered one cycle after read enable)
- o_rb_read_enable  out  1  bank debug read enable
- o_rb_read_address  out  NB_ADDR  bank debug read address
- o_halt  out  1  high while busy; gates the bank's normal-operation enable low
- o_tx_data  out  NB_BYTE  byte to transmitter
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  transmitter accepts byte when valid && ready at a rising edge
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the last byte is accepted

## Operation
- States: IDLE, REQ, WAIT, SEND, DONE.
- IDLE:
  - i_start=1 -> REQ; reg index cleared to 0.
  - i_start=0 -> stay in IDLE.
- REQ: o_rb_read_enable=1, o_rb_read_address=index; -> WAIT unconditionally.
- WAIT: read enable low, address held. At the closing edge, i_rb_data is loaded into the NB_DATA shift register and the byte counter is cleared. -> SEND.
- SEND: o_tx_valid=1, o_tx_data=shift[NB_BYTE-1:0].
  - On handshake: shift right by NB_BYTE and increment the byte counter.
  - After handshake of byte NB_DATA/NB_BYTE-1:
    - If index==BANK_DEPTH-1 -> DONE.
    - Otherwise index+1 -> REQ.
- DONE: o_done=1 for exactly one cycle; -> IDLE.
- o_halt = o_busy = (state != IDLE).
- Counters:
  - The index counter is NB_ADDR bits wide and never wraps past BANK_DEPTH-1.
  - The byte counter is clog2(NB_DATA/NB_BYTE) bits wide, minimum 1 bit.
- i_start while busy is ignored (not queued).

## Timing
- Reset (i_reset=0 at an edge): state IDLE. All outputs are 0: o_rb_read_enable, o_rb_read_address, o_halt, o_tx_data, o_tx_valid, o_busy, o_done. Index, byte counter and shift register are also cleared.
- Reset mid-dump takes effect at the same edge. o_tx_valid may drop without a handshake only in this case. The next i_start restarts from register 0.
- Start latency: i_start sampled at edge 0 -> REQ, o_halt and o_busy high in cycle 1.
- Read latency: address issued in REQ; data sampled at the end of WAIT, i.e. the second edge after REQ begins.
- Handshake rules:
  - Once o_tx_valid rises, it stays high and o_tx_data stays stable until i_tx_ready=1.
  - No combinational path from i_tx_ready to o_tx_valid.
- Throughput with i_tx_ready tied high:
  - 2 + NB_DATA/NB_BYTE = 6 cycles per register.
  - Defaults: first REQ in cycle 1, last byte accepted at the end of cycle 192, o_done high in cycle 193, IDLE in cycle 194.
- Back-to-back: i_start high in the cycle o_done is high is ignored. It is accepted from the cycle after.

## Test plan
- **Basic dump:** bank preloaded r0=255, r1=10, r2=200, r3=420, others 0; i_tx_ready=1; pulse i_start -> byte stream begins FF 00 00 00 0A 00 00 00 C8 00 00 00 A4 01 00 00. Expect 128 bytes total and o_done in cycle 193.
- **Address sequence:** monitor the read port -> o_rb_read_enable is high for exactly 32 single cycles. Addresses are 0,1,...,31 in order, 6 cycles apart, and never asserted outside REQ.
- **Backpressure:** hold i_tx_ready=0 for 5 cycles when byte 2 of r3 (0x00) is presented, plus random ready stalls -> o_tx_valid held and o_tx_data unchanged during stalls. No byte is lost or duplicated, and the stream still matches the basic dump.
- **Start while busy:** pulse i_start at cycles 10 and 100 of a dump -> no restart, single o_done, and exactly 128 bytes.
- **Reset mid-dump:** drive i_reset=0 during SEND of r5 -> at the next edge all outputs are 0 and the state is IDLE. After reset release, i_start -> the dump restarts at r0 with first byte FF.
- **Halt/busy:** o_halt and o_busy are high from cycle 1 through cycle 193 inclusive and low otherwise. o_done is high only in cycle 193.
